// File: rtl/lt_int_serial_if.sv
`default_nettype none
// ============================================================================
//  Module   : lt_int_serial_if
//  Brief    : Operand/result handshake bundle for the bit-serial less-than
//             comparator. The EQ signal exists only when LT_SERIAL_EQ_EN is
//             defined.
//  Revision : 1.0  initial release
// ============================================================================
interface lt_int_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic             Y;
`ifdef LT_SERIAL_EQ_EN
    logic             EQ;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Y, EQ
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Y, EQ
    );
`else
    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Y
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Y
    );
`endif
endinterface
`default_nettype wire

// File: rtl/lt_int_serial.sv
`default_nettype none
// ============================================================================
//  Module   : lt_int_serial
//  Brief    : Bit-serial signed/unsigned A < B comparator, LSB first through a
//             single borrow flop. Define LT_SERIAL_EQ_EN to add the EQ output.
//  Revision : 1.0  initial release
// ============================================================================
module lt_int_serial #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    lt_int_serial_if.slave  bus
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   w_b_nxt;
    logic               r_borrow;
    logic               w_borrow_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_y;
    logic               w_y_nxt;

    logic               w_bit_a;
    logic               w_bit_b;
    logic               w_same;
    logic               w_borrow_bit;
    logic               w_y_msb;

    assign w_bit_a      = r_a_sh[0];
    assign w_bit_b      = r_b_sh[0];
    assign w_same       = ~(w_bit_a ^ w_bit_b);
    assign w_borrow_bit = (~w_bit_a & w_bit_b) | (w_same & r_borrow);

    // In two's complement the MSB carries negative weight, so the sign of the
    // top-bit borrow term is flipped for the signed compare.
    generate
        if (SIGNED) begin : g_msb_signed
            assign w_y_msb = (w_bit_a & ~w_bit_b) | (w_same & r_borrow);
        end else begin : g_msb_unsigned
            assign w_y_msb = w_borrow_bit;
        end
    endgenerate

`ifdef LT_SERIAL_EQ_EN
    logic r_eq;
    logic w_eq_nxt;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a_sh;
        w_b_nxt      = r_b_sh;
        w_borrow_nxt = r_borrow;
        w_cnt_nxt    = r_cnt;
        w_y_nxt      = r_y;
`ifdef LT_SERIAL_EQ_EN
        w_eq_nxt     = r_eq;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_a_nxt      = bus.A;
                    w_b_nxt      = bus.B;
                    w_borrow_nxt = 1'b0;
                    w_cnt_nxt    = '0;
`ifdef LT_SERIAL_EQ_EN
                    w_eq_nxt     = 1'b1;
`endif
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                w_a_nxt = {1'b0, r_a_sh[WIDTH-1:1]};
                w_b_nxt = {1'b0, r_b_sh[WIDTH-1:1]};
`ifdef LT_SERIAL_EQ_EN
                if (!w_same) begin
                    w_eq_nxt = 1'b0;
                end
`endif
                if (r_cnt == c_LAST) begin
                    w_y_nxt     = w_y_msb;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_borrow_nxt = w_borrow_bit;
                    w_cnt_nxt    = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_y      <= 1'b0;
`ifdef LT_SERIAL_EQ_EN
            r_eq     <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_a_sh   <= w_a_nxt;
            r_b_sh   <= w_b_nxt;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= w_cnt_nxt;
            r_y      <= w_y_nxt;
`ifdef LT_SERIAL_EQ_EN
            r_eq     <= w_eq_nxt;
`endif
        end
    end

    // Handshake flags decode straight from the state register.
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.Y         = r_y;
`ifdef LT_SERIAL_EQ_EN
    assign bus.EQ        = r_eq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lt_int_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lt_int_serial
//  Brief    : Directed and randomized bench running a signed and an unsigned
//             lt_int_serial side by side from the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lt_int_serial;

    localparam int WIDTH   = 8;
    localparam int N_RAND  = 3000;
    localparam int MAX_CYC = 80000;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a_in      = '0;
    logic [WIDTH-1:0] b_in      = '0;

    always #5 clk = ~clk;

    lt_int_serial_if #(.WIDTH(WIDTH)) if_s ();
    lt_int_serial_if #(.WIDTH(WIDTH)) if_u ();

    assign if_s.in_valid  = in_valid;
    assign if_s.A         = a_in;
    assign if_s.B         = b_in;
    assign if_s.out_ready = out_ready;
    assign if_u.in_valid  = in_valid;
    assign if_u.A         = a_in;
    assign if_u.B         = b_in;
    assign if_u.out_ready = out_ready;

    lt_int_serial #(.WIDTH(WIDTH), .SIGNED(1'b1)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s.slave)
    );

    lt_int_serial #(.WIDTH(WIDTH), .SIGNED(1'b0)) u_dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_u.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input bit sgn);
        if (sgn) return ($signed(a) < $signed(b));
        return (a < b);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int k = 0;
        while (!(if_s.in_ready && if_u.in_ready) && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check_eq("idle_timeout", k, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ready_s"},  if_s.in_ready,  1);
        check_eq({tag, "_in_ready_u"},  if_u.in_ready,  1);
        check_eq({tag, "_out_valid_s"}, if_s.out_valid, 0);
        check_eq({tag, "_out_valid_u"}, if_u.out_valid, 0);
        check_eq({tag, "_y_s"},         if_s.Y,         0);
        check_eq({tag, "_y_u"},         if_u.Y,         0);
`ifdef LT_SERIAL_EQ_EN
        check_eq({tag, "_eq_s"},        if_s.EQ,        0);
`endif
    endtask

    // One full transaction with latency check, optional back-pressure hold.
    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic exp_s, input logic exp_u, input int hold);
        int k;
        wait_idle();
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        tick();
        in_valid = 1'b0;
        a_in     = ~a;
        b_in     = ~b;
        k = 0;
        while (!if_s.out_valid && k < 3 * WIDTH) begin
            tick();
            k++;
        end
        check_eq({tag, "_latency"},  k,              WIDTH);
        check_eq({tag, "_valid_u"},  if_u.out_valid, 1);
        check_eq({tag, "_y_s"},      if_s.Y,         exp_s);
        check_eq({tag, "_y_u"},      if_u.Y,         exp_u);
        check_eq({tag, "_model_s"},  if_s.Y,         ref_lt(a, b, 1'b1));
        check_eq({tag, "_model_u"},  if_u.Y,         ref_lt(a, b, 1'b0));
`ifdef LT_SERIAL_EQ_EN
        check_eq({tag, "_eq_s"},     if_s.EQ,        (a == b));
        check_eq({tag, "_eq_u"},     if_u.EQ,        (a == b));
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in     = WIDTH'($urandom);
            b_in     = WIDTH'($urandom);
            tick();
            check_eq({tag, "_hold_valid"}, if_s.out_valid, 1);
            check_eq({tag, "_hold_ready"}, if_s.in_ready,  0);
            check_eq({tag, "_hold_y_s"},   if_s.Y,         exp_s);
            check_eq({tag, "_hold_y_u"},   if_u.Y,         exp_u);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_release_ready"}, if_s.in_ready,  1);
        check_eq({tag, "_release_valid"}, if_s.out_valid, 0);
    endtask

    typedef struct {
        logic ys;
        logic yu;
        logic eq;
    } exp_t;

    initial begin
        exp_t q[$];
        exp_t e;
        int   done;
        int   cyc;
        int   seen;

        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        directed("s80_7f", 8'h80, 8'h7F, 1'b1, 1'b0, 0);
        directed("sff_fe", 8'hFF, 8'hFE, 1'b0, 1'b0, 0);
        directed("s05_05", 8'h05, 8'h05, 1'b0, 1'b0, 0);
        directed("u7f_80", 8'h7F, 8'h80, 1'b0, 1'b1, 5);
        directed("sfe_ff", 8'hFE, 8'hFF, 1'b1, 1'b1, 0);

        // Abort a run in its 4th RUN cycle; Y was left at 1 by the last test.
        wait_idle();
        in_valid = 1'b1;
        a_in     = 8'h33;
        b_in     = 8'h44;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("midrun");
        seen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            tick();
            if (if_s.out_valid || if_u.out_valid) seen++;
        end
        check_eq("midrun_discard", seen, 0);
        directed("post_rst", 8'h01, 8'h02, 1'b1, 1'b1, 0);

        done = 0;
        cyc  = 0;
        while (done < N_RAND && cyc < MAX_CYC) begin
            in_valid  = ($urandom % 4) != 0;
            a_in      = WIDTH'($urandom);
            b_in      = WIDTH'($urandom);
            out_ready = ($urandom % 3) != 0;
            if (in_valid && if_s.in_ready) begin
                e.ys = ref_lt(a_in, b_in, 1'b1);
                e.yu = ref_lt(a_in, b_in, 1'b0);
                e.eq = (a_in == b_in);
                q.push_back(e);
            end
            if (if_s.out_valid && out_ready) begin
                check_eq("rand_pending", q.size(), 1);
                check_eq("rand_valid_u", if_u.out_valid, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check_eq("rand_y_s", if_s.Y, e.ys);
                    check_eq("rand_y_u", if_u.Y, e.yu);
`ifdef LT_SERIAL_EQ_EN
                    check_eq("rand_eq_s", if_s.EQ, e.eq);
`endif
                end
                done++;
            end
            tick();
            cyc++;
        end
        check_eq("rand_count", done, N_RAND);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3 * WIDTH && q.size() > 0; i++) begin
            if (if_s.out_valid) begin
                e = q.pop_front();
                check_eq("drain_y_s", if_s.Y, e.ys);
                check_eq("drain_y_u", if_u.Y, e.yu);
            end
            tick();
        end
        check_eq("drain_empty", q.size(), 0);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
